io_hub: RTL and testbench

Parametrised memory-mapped I/O hub that replaces the ad-hoc LED blinker and the raw PS/2 read path in the top level. It buffers keyboard scancodes in a FIFO, drives the LED bank with software-selectable modes, provides a free-running cycle timer, and answers CPU loads and stores in a small register window, with the same one-cycle read latency as `mem`. It sits between the CPU/memory data port and the board I/O in `jpeb`.

---
 rtl/io_hub_pkg.sv | 26 ++
 rtl/io_hub_if.sv | 23 ++
 rtl/io_hub_sync_fifo.sv | 49 ++++
 rtl/io_hub.sv | 130 +++++++++++++
 tb/tb_io_hub.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_hub_pkg.sv
// Shared constants for io_hub: register offsets inside the 8-word window, LED mode
// encodings and KBD_STATUS bit positions.
package io_hub_pkg;

  localparam logic [2:0] KBD_DATA   = 3'd0;
  localparam logic [2:0] KBD_STATUS = 3'd1;
  localparam logic [2:0] LED        = 3'd2;
  localparam logic [2:0] LED_MODE   = 3'd3;
  localparam logic [2:0] TIMER_LO   = 3'd4;
  localparam logic [2:0] TIMER_HI   = 3'd5;

  typedef enum logic [1:0] {
    LedStatic = 2'd0,
    LedBlink  = 2'd1,
    LedCount  = 2'd2,
    LedKbd    = 2'd3
  } led_mode_e;

  localparam int unsigned StNonEmpty = 0;
  localparam int unsigned StFull     = 1;
  localparam int unsigned StOverflow = 2;
  localparam int unsigned StCountLsb = 4;

  localparam int unsigned TimerW = 32;

endpackage

// File: rtl/io_hub_if.sv
// CPU data-port bus into io_hub: read strobe/address with registered read data, plus a
// single-cycle write strobe/address/data.
interface io_hub_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
) ();
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              wen;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  modport master (
    output ren, raddr, wen, waddr, wdata,
    input  rdata
  );

  modport slave (
    input  ren, raddr, wen, waddr, wdata,
    output rdata
  );
endinterface

// File: rtl/io_hub_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam logic [AW:0] PtrOne = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO may still accept a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped I/O hub with scancode FIFO, LED modes and a 32-bit cycle timer.
// Register reads have one cycle of latency; rdata holds until the next read strobe.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE      = 16'hFF00,
  parameter int unsigned       KBD_DEPTH = 8,
  parameter int unsigned       LED_W     = 8,
  parameter int unsigned       BLINK_BIT = 24
) (
  input  logic             clk,
  input  logic             reset,
  io_hub_if.slave          bus,
  input  logic             kbd_valid,
  input  logic [15:0]      kbd_code,
  output logic [LED_W-1:0] leds,
  output logic             status_led,
  output logic             kbd_irq
);

  localparam int unsigned CW = $clog2(KBD_DEPTH) + 1;

  logic              rd_hit, wr_hit;
  logic [2:0]        rd_off, wr_off;
  logic              kbd_rd, ovf_set, ovf_clr;
  logic              fifo_full, fifo_empty;
  logic [15:0]       fifo_head;
  logic [CW-1:0]     fifo_count;
  logic [7:0]        status;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] rdata_q;
  logic [LED_W-1:0]  led_q;
  led_mode_e         mode_q;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic [LED_W-1:0]  leds_q, leds_d;

  assign rd_hit = (bus.raddr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
  assign wr_hit = (bus.waddr[ADDR_W-1:3] == BASE[ADDR_W-1:3]) && bus.wen;
  assign rd_off = bus.raddr[2:0];
  assign wr_off = bus.waddr[2:0];

  assign kbd_rd  = bus.ren && rd_hit && (rd_off == KBD_DATA);
  // A full FIFO always has a head to pop, so only a data read rescues the incoming code.
  assign ovf_set = kbd_valid && fifo_full && !kbd_rd;
  assign ovf_clr = wr_hit && (wr_off == KBD_STATUS) && bus.wdata[StOverflow];

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (kbd_valid),
    .pop   (kbd_rd),
    .wdata (kbd_code),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                       = '0;
    status[StNonEmpty]           = !fifo_empty;
    status[StFull]               = fifo_full;
    status[StOverflow]           = ovf_q;
    status[StCountLsb +: 4]      = 4'(fifo_count);
  end

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_off)
        KBD_DATA:   rd_val = fifo_empty ? '0 : DATA_W'(fifo_head);
        KBD_STATUS: rd_val = DATA_W'(status);
        LED:        rd_val = DATA_W'(led_q);
        LED_MODE:   rd_val = DATA_W'(mode_q);
        TIMER_LO:   rd_val = DATA_W'(timer_q[15:0]);
        TIMER_HI:   rd_val = DATA_W'(timer_q[31:16]);
        default:    rd_val = '0;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr_hit && (wr_off == TIMER_LO)) timer_d = {timer_q[31:16], bus.wdata[15:0]};
    if (wr_hit && (wr_off == TIMER_HI)) timer_d = {bus.wdata[15:0], timer_q[15:0]};
    ovf_d = (ovf_q && !ovf_clr) || ovf_set;
  end

  always_comb begin
    leds_d = '0;
    unique case (mode_q)
      LedStatic: leds_d = led_q;
      LedBlink:  leds_d = led_q & {LED_W{timer_q[BLINK_BIT]}};
      LedCount:  leds_d = LED_W'(timer_q >> BLINK_BIT);
      LedKbd:    leds_d = fifo_empty ? '0 : fifo_head[LED_W-1:0];
      default:   leds_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      led_q   <= '0;
      mode_q  <= LedStatic;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      leds_q  <= '0;
    end else begin
      if (bus.ren) rdata_q <= rd_val;
      if (wr_hit && (wr_off == LED))      led_q  <= bus.wdata[LED_W-1:0];
      if (wr_hit && (wr_off == LED_MODE)) mode_q <= led_mode_e'(bus.wdata[1:0]);
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      leds_q  <= leds_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign leds       = leds_q;
  assign status_led = timer_q[BLINK_BIT];
  assign kbd_irq    = !fifo_empty;

endmodule

// File: tb/tb_io_hub.sv
// Bench for io_hub: a reference model (queue-based FIFO, plain 32-bit timer) runs every cycle,
// alongside a constant-expectation vector table and hand-written corner-case sequences.
module tb_io_hub;
  import io_hub_pkg::*;

  localparam logic [15:0] Base   = 16'hFF00;
  localparam int          Depth  = 8;
  localparam int          BlinkB = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic [7:0]  leds;
  logic        status_led, kbd_irq;

  always #5 clk = ~clk;

  io_hub_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  io_hub #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .BASE      (Base),
    .KBD_DEPTH (Depth),
    .LED_W     (8),
    .BLINK_BIT (BlinkB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .kbd_valid  (kbd_valid),
    .kbd_code   (kbd_code),
    .leds       (leds),
    .status_led (status_led),
    .kbd_irq    (kbd_irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [15:0] m_q[$];
  logic        m_ovf;
  logic [7:0]  m_led;
  logic [1:0]  m_mode;
  logic [31:0] m_timer;
  logic [15:0] m_rdata;
  logic [7:0]  m_leds;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(logic ren, logic [15:0] raddr, logic wen, logic [15:0] waddr,
                       logic [15:0] wdata, logic kv, logic [15:0] kc);
    bus.ren = ren; bus.raddr = raddr; bus.wen = wen; bus.waddr = waddr; bus.wdata = wdata;
    kbd_valid = kv; kbd_code = kc;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
  endtask

  function automatic int win_off(logic [15:0] a);
    int d = int'(a) - int'(Base);
    return (d >= 0 && d < 8) ? d : -1;
  endfunction

  task automatic model_step();
    int          roff, woff;
    logic [7:0]  nl;
    logic [31:0] nt;
    logic [15:0] rv;
    logic        clr, drop;
    if (reset) begin
      m_q.delete(); m_ovf = 0; m_led = 0; m_mode = 0; m_timer = 0; m_rdata = 0; m_leds = 0;
      return;
    end
    case (m_mode)
      2'd0:    nl = m_led;
      2'd1:    nl = m_timer[BlinkB] ? m_led : 8'h00;
      2'd2:    nl = 8'(m_timer / (32'd1 << BlinkB));
      default: nl = (m_q.size() > 0) ? m_q[0][7:0] : 8'h00;
    endcase
    if (bus.ren) begin
      rv = 16'h0;
      roff = win_off(bus.raddr);
      case (roff)
        0: if (m_q.size() > 0) rv = m_q.pop_front();
        1: rv = {8'h00, 4'(m_q.size()), 1'b0, m_ovf, m_q.size() == Depth, m_q.size() > 0};
        2: rv = {8'h00, m_led};
        3: rv = {14'h0, m_mode};
        4: rv = m_timer[15:0];
        5: rv = m_timer[31:16];
        default: rv = 16'h0;
      endcase
      m_rdata = rv;
    end
    clr = 0;
    nt = m_timer + 32'd1;
    woff = bus.wen ? win_off(bus.waddr) : -1;
    case (woff)
      1: clr = bus.wdata[2];
      2: m_led = bus.wdata[7:0];
      3: m_mode = bus.wdata[1:0];
      4: nt = {m_timer[31:16], bus.wdata};
      5: nt = {bus.wdata, m_timer[15:0]};
      default: ;
    endcase
    drop = 0;
    if (kbd_valid) begin
      if (m_q.size() < Depth) m_q.push_back(kbd_code);
      else drop = 1;
    end
    m_ovf   = (m_ovf && !clr) || drop;
    m_timer = nt;
    m_leds  = nl;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check("model_rdata", 32'(bus.rdata), 32'(m_rdata));
    check("model_leds", 32'(leds), 32'(m_leds));
    check("model_irq", 32'(kbd_irq), 32'(m_q.size() > 0));
    check("model_status_led", 32'(status_led), 32'(m_timer[BlinkB]));
  endtask

  task automatic rd(logic [2:0] off);
    drive(1'b1, Base + 16'(off), 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    cyc();
  endtask

  task automatic wr(logic [2:0] off, logic [15:0] d);
    drive(1'b0, 16'h0, 1'b1, Base + 16'(off), d, 1'b0, 16'h0);
    cyc();
  endtask

  typedef struct {
    logic        ren;
    logic [15:0] raddr;
    logic        wen;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic        kv;
    logic [15:0] kc;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_leds;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t mk(logic ren, logic [15:0] ra, logic wen, logic [15:0] wa,
                              logic [15:0] wd, logic kv, logic [15:0] kc,
                              logic [15:0] er, logic [7:0] el, logic ei);
    vec_t v;
    v.ren = ren; v.raddr = ra; v.wen = wen; v.waddr = wa; v.wdata = wd; v.kv = kv; v.kc = kc;
    v.exp_rdata = er; v.exp_leds = el; v.exp_irq = ei;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        tbl[$];
    logic [15:0] drain_exp[9];
    logic [7:0]  prev;
    int          run, ntr;
    logic        seen;

    reset = 1'b1;
    idle();
    kbd_valid = 1'b1; kbd_code = 16'h00EE;  // dropped while in reset
    repeat (3) cyc();
    reset = 1'b0;
    idle();

    tbl.push_back(mk(1, Base + 4, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 5, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 3, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h001C, 16'h0000, 8'h00, 1));
    tbl.push_back(mk(1, Base + 1, 0, 0, 0, 1, 16'h0032, 16'h0011, 8'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0021, 16'h0011, 8'h00, 1));
    tbl.push_back(mk(1, Base + 0, 0, 0, 0, 0, 0, 16'h001C, 8'h00, 1));
    tbl.push_back(mk(1, Base + 0, 0, 0, 0, 0, 0, 16'h0032, 8'h00, 1));
    tbl.push_back(mk(1, Base + 0, 0, 0, 0, 0, 0, 16'h0021, 8'h00, 0));
    tbl.push_back(mk(1, Base + 0, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 1, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 1, Base + 2, 16'h00A5, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(mk(1, 16'hFF08, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 6, 0, 0, 0, 0, 0, 16'h0000, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 2, 1, 16'hFE02, 16'h0033, 0, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 2, 1, Base + 2, 16'h003C, 0, 0, 16'h00A5, 8'hA5, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h003C, 8'h3C, 0));
    tbl.push_back(mk(0, 0, 1, Base + 2, 16'h00A5, 0, 0, 16'h003C, 8'h3C, 0));
    tbl.push_back(mk(1, Base + 2, 0, 0, 0, 0, 0, 16'h00A5, 8'hA5, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].ren, tbl[i].raddr, tbl[i].wen, tbl[i].waddr, tbl[i].wdata,
            tbl[i].kv, tbl[i].kc);
      cyc();
      check($sformatf("tbl%0d_rdata", i), 32'(bus.rdata), 32'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d_leds", i), 32'(leds), 32'(tbl[i].exp_leds));
      check($sformatf("tbl%0d_irq", i), 32'(kbd_irq), 32'(tbl[i].exp_irq));
    end

    // Overflow: nine pushes into an eight-deep FIFO.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0040 + 16'(i));
      cyc();
    end
    rd(KBD_STATUS);
    check("ovf_status", 32'(bus.rdata), 32'h87);
    wr(KBD_STATUS, 16'h0004);
    rd(KBD_STATUS);
    check("ovf_cleared", 32'(bus.rdata), 32'h83);

    // Full FIFO: pop and push in the same cycle.
    drive(1'b1, Base + 16'(KBD_DATA), 1'b0, 16'h0, 16'h0, 1'b1, 16'h0099);
    cyc();
    check("full_popush_data", 32'(bus.rdata), 32'h40);
    rd(KBD_STATUS);
    check("full_popush_status", 32'(bus.rdata), 32'h83);
    for (int i = 0; i < 8; i++) drain_exp[i] = 16'h0041 + 16'(i);
    drain_exp[7] = 16'h0099;
    for (int i = 0; i < 8; i++) begin
      rd(KBD_DATA);
      check($sformatf("drain%0d", i), 32'(bus.rdata), 32'(drain_exp[i]));
    end
    rd(KBD_STATUS);
    check("drained_status", 32'(bus.rdata), 32'h00);

    // Empty FIFO: push and pop in the same cycle.
    drive(1'b1, Base + 16'(KBD_DATA), 1'b0, 16'h0, 16'h0, 1'b1, 16'h0055);
    cyc();
    check("empty_popush_data", 32'(bus.rdata), 32'h0);
    rd(KBD_STATUS);
    check("empty_popush_status", 32'(bus.rdata), 32'h11);
    rd(KBD_DATA);
    check("empty_popush_kept", 32'(bus.rdata), 32'h55);

    // KBD mode shows the head scancode's low bits.
    drive(1'b0, 16'h0, 1'b1, Base + 16'(LED_MODE), 16'h0003, 1'b1, 16'h01C3);
    cyc();
    idle();
    cyc();
    check("kbd_mode_leds", 32'(leds), 32'hC3);
    rd(KBD_DATA);
    idle();
    cyc();
    check("kbd_mode_empty", 32'(leds), 32'h00);
    wr(LED, 16'h00A5);

    // Blink: with BLINK_BIT=3 the LEDs toggle between 0xA5 and 0 every 8 cycles.
    wr(LED_MODE, 16'h0001);
    idle();
    cyc();
    prev = leds; run = 0; ntr = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      run++;
      if (leds != prev) begin
        check("blink_alt", 32'(leds ^ prev), 32'hA5);
        if (seen) check("blink_period", 32'(run), 32'd8);
        seen = 1; run = 0; ntr++;
      end
      prev = leds;
    end
    check("blink_transitions", 32'(ntr >= 4), 32'd1);

    wr(LED_MODE, 16'h0000);
    idle();
    cyc();
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("static_steady", 32'(leds), 32'hA5);
    end

    // Timer halves, same-cycle read of the old value, and wrap.
    wr(TIMER_LO, 16'h1234);
    wr(TIMER_HI, 16'h0000);
    drive(1'b1, Base + 16'(TIMER_LO), 1'b1, Base + 16'(TIMER_LO), 16'hFFFF, 1'b0, 16'h0);
    cyc();
    check("timer_lo_old", 32'(bus.rdata), 32'h1234);
    drive(1'b1, Base + 16'(TIMER_HI), 1'b1, Base + 16'(TIMER_HI), 16'hFFFF, 1'b0, 16'h0);
    cyc();
    check("timer_hi_old", 32'(bus.rdata), 32'h0000);
    rd(TIMER_HI);
    check("timer_hi_max", 32'(bus.rdata), 32'hFFFF);
    rd(TIMER_LO);
    check("timer_wrap_lo", 32'(bus.rdata), 32'h0000);
    rd(TIMER_HI);
    check("timer_wrap_hi", 32'(bus.rdata), 32'h0000);

    // Reset in the middle of a read, with a scancode arriving.
    rd(LED);
    check("pre_reset_led", 32'(bus.rdata), 32'hA5);
    drive(1'b1, Base + 16'(LED), 1'b0, 16'h0, 16'h0, 1'b1, 16'h0077);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_rdata", 32'(bus.rdata), 32'h0);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_irq", 32'(kbd_irq), 32'h0);
    check("reset_status_led", 32'(status_led), 32'h0);
    rd(KBD_STATUS);
    check("reset_fifo_status", 32'(bus.rdata), 32'h0);

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bus.ren   = ($urandom_range(0, 1) == 1);
      bus.raddr = ($urandom_range(0, 9) < 8) ? Base + 16'($urandom_range(0, 7)) : 16'($urandom);
      bus.wen   = ($urandom_range(0, 3) == 0);
      bus.waddr = ($urandom_range(0, 9) < 8) ? Base + 16'($urandom_range(0, 7)) : 16'($urandom);
      bus.wdata = 16'($urandom);
      kbd_valid = ($urandom_range(0, 9) < 4);
      kbd_code  = 16'($urandom);
      reset     = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
